// File: rtl/rc4_sched.sv
// Top-level sequencer for the RC4 datapath: init, key shuffle, decrypt/check, S-memory arbitration.
// Optional key search is compiled in with RC4_KEY_SEARCH_EN (adds NEXT_KEY and the KEY_MAX parameter).
module rc4_sched
`ifdef RC4_KEY_SEARCH_EN
  #(
    parameter logic [23:0] KEY_MAX = 24'h3FFFFF
  )
`endif
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] key_in,
  output logic        busy,
  output logic        done,
  output logic        success,
  output logic [23:0] cur_key,
  output logic        init_start,
  output logic        shuf_start,
  output logic        dec_start,
  input  logic        init_done,
  input  logic        shuf_done,
  input  logic        dec_done,
  input  logic        dec_fail,
  input  logic [7:0]  init_addr,
  input  logic [7:0]  shuf_addr,
  input  logic [7:0]  dec_addr,
  input  logic [7:0]  init_data,
  input  logic [7:0]  shuf_data,
  input  logic [7:0]  dec_data,
  input  logic        init_wren,
  input  logic        shuf_wren,
  input  logic        dec_wren,
  output logic [7:0]  s_addr,
  output logic [7:0]  s_data,
  output logic        s_wren
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    INIT_GO   = 4'd1,
    INIT_WAIT = 4'd2,
    SHUF_GO   = 4'd3,
    SHUF_WAIT = 4'd4,
    DEC_GO    = 4'd5,
    DEC_WAIT  = 4'd6,
`ifdef RC4_KEY_SEARCH_EN
    NEXT_KEY  = 4'd7,
`endif
    PASS      = 4'd8,
    FAIL      = 4'd9
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [23:0] cur_key_r;
  logic [23:0] key_next_s;
  logic        success_r;
  logic        success_next_s;
  logic        busy_r;
  logic        done_r;
  logic        init_start_r;
  logic        shuf_start_r;
  logic        dec_start_r;

  // Next-state, key and result decisions from the current state.
  always_comb begin
    next_state_s   = state_r;
    key_next_s     = cur_key_r;
    success_next_s = success_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s   = INIT_GO;
          key_next_s     = key_in;
          success_next_s = 1'b0;
        end else begin
          next_state_s = IDLE;
        end
      end
      INIT_GO:   next_state_s = INIT_WAIT;
      INIT_WAIT: begin
        if (init_done) begin
          next_state_s = SHUF_GO;
        end else begin
          next_state_s = INIT_WAIT;
        end
      end
      SHUF_GO:   next_state_s = SHUF_WAIT;
      SHUF_WAIT: begin
        if (shuf_done) begin
          next_state_s = DEC_GO;
        end else begin
          next_state_s = SHUF_WAIT;
        end
      end
      DEC_GO:    next_state_s = DEC_WAIT;
      DEC_WAIT: begin
        if (dec_done && !dec_fail) begin
          next_state_s   = PASS;
          success_next_s = 1'b1;
        end else if (dec_done) begin
`ifdef RC4_KEY_SEARCH_EN
          next_state_s = NEXT_KEY;
`else
          next_state_s   = FAIL;
          success_next_s = 1'b0;
`endif
        end else begin
          next_state_s = DEC_WAIT;
        end
      end
`ifdef RC4_KEY_SEARCH_EN
      NEXT_KEY: begin
        // Stop at KEY_MAX so the candidate counter never wraps back to 0.
        if (cur_key_r == KEY_MAX) begin
          next_state_s   = FAIL;
          success_next_s = 1'b0;
        end else begin
          next_state_s = INIT_GO;
          key_next_s   = cur_key_r + 24'd1;
        end
      end
`endif
      PASS:    next_state_s = IDLE;
      FAIL:    next_state_s = IDLE;
      default: begin
        next_state_s   = IDLE;
        success_next_s = 1'b0;
      end
    endcase
  end

  // State, key, result and decoded control flops; outputs come straight from these.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      cur_key_r    <= 24'd0;
      success_r    <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      init_start_r <= 1'b0;
      shuf_start_r <= 1'b0;
      dec_start_r  <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      cur_key_r    <= key_next_s;
      success_r    <= success_next_s;
      busy_r       <= (next_state_s != IDLE);
      done_r       <= (next_state_s == PASS) || (next_state_s == FAIL);
      init_start_r <= (next_state_s == INIT_GO);
      shuf_start_r <= (next_state_s == SHUF_GO);
      dec_start_r  <= (next_state_s == DEC_GO);
    end
  end

  // S-memory grant keyed on the registered state; ungranted engines never reach the memory.
  always_comb begin
    s_addr = 8'd0;
    s_data = 8'd0;
    s_wren = 1'b0;
    case (state_r)
      INIT_GO, INIT_WAIT: begin
        s_addr = init_addr;
        s_data = init_data;
        s_wren = init_wren;
      end
      SHUF_GO, SHUF_WAIT: begin
        s_addr = shuf_addr;
        s_data = shuf_data;
        s_wren = shuf_wren;
      end
      DEC_GO, DEC_WAIT: begin
        s_addr = dec_addr;
        s_data = dec_data;
        s_wren = dec_wren;
      end
      default: begin
        s_addr = 8'd0;
        s_data = 8'd0;
        s_wren = 1'b0;
      end
    endcase
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign success    = success_r;
  assign cur_key    = cur_key_r;
  assign init_start = init_start_r;
  assign shuf_start = shuf_start_r;
  assign dec_start  = dec_start_r;

endmodule

// File: tb/tb_rc4_sched.sv
// Directed self-checking bench for rc4_sched; search scenarios run when RC4_KEY_SEARCH_EN is defined.
module tb_rc4_sched;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [23:0] key_in;
  logic        busy, done, success;
  logic [23:0] cur_key;
  logic        init_start, shuf_start, dec_start;
  logic        init_done, shuf_done, dec_done, dec_fail;
  logic [7:0]  init_addr, shuf_addr, dec_addr;
  logic [7:0]  init_data, shuf_data, dec_data;
  logic        init_wren, shuf_wren, dec_wren;
  logic [7:0]  s_addr, s_data;
  logic        s_wren;

  int passed = 0;
  int total  = 0;

`ifdef RC4_KEY_SEARCH_EN
  rc4_sched #(.KEY_MAX(24'h000015)) dut (
    .clk(clk), .reset(reset), .start(start), .key_in(key_in),
    .busy(busy), .done(done), .success(success), .cur_key(cur_key),
    .init_start(init_start), .shuf_start(shuf_start), .dec_start(dec_start),
    .init_done(init_done), .shuf_done(shuf_done), .dec_done(dec_done), .dec_fail(dec_fail),
    .init_addr(init_addr), .shuf_addr(shuf_addr), .dec_addr(dec_addr),
    .init_data(init_data), .shuf_data(shuf_data), .dec_data(dec_data),
    .init_wren(init_wren), .shuf_wren(shuf_wren), .dec_wren(dec_wren),
    .s_addr(s_addr), .s_data(s_data), .s_wren(s_wren)
  );
`else
  rc4_sched dut (
    .clk(clk), .reset(reset), .start(start), .key_in(key_in),
    .busy(busy), .done(done), .success(success), .cur_key(cur_key),
    .init_start(init_start), .shuf_start(shuf_start), .dec_start(dec_start),
    .init_done(init_done), .shuf_done(shuf_done), .dec_done(dec_done), .dec_fail(dec_fail),
    .init_addr(init_addr), .shuf_addr(shuf_addr), .dec_addr(dec_addr),
    .init_data(init_data), .shuf_data(shuf_data), .dec_data(dec_data),
    .init_wren(init_wren), .shuf_wren(shuf_wren), .dec_wren(dec_wren),
    .s_addr(s_addr), .s_data(s_data), .s_wren(s_wren)
  );
`endif

  always #5 clk = ~clk;

  // {busy, done, success, init_start, shuf_start, dec_start}
  function automatic logic [5:0] ctl();
    ctl = {busy, done, success, init_start, shuf_start, dec_start};
  endfunction

  function automatic logic [16:0] mem();
    mem = {s_addr, s_data, s_wren};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_init();
    init_done = 1'b1; tick(); init_done = 1'b0;
  endtask

  task automatic pulse_shuf();
    shuf_done = 1'b1; tick(); shuf_done = 1'b0;
  endtask

  task automatic pulse_dec(input logic fail);
    dec_fail = fail; dec_done = 1'b1; tick(); dec_done = 1'b0; dec_fail = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    total++; if (ctl() !== 6'b000000) $display("FAIL reset_ctl: got %b expected %b", ctl(), 6'b000000); else passed++;
    total++; if (cur_key !== 24'h000000) $display("FAIL reset_key: got %h expected %h", cur_key, 24'h000000); else passed++;
    reset = 1'b0;
    tick(); tick();
    total++; if (ctl() !== 6'b000000) $display("FAIL idle_ctl: got %b expected %b", ctl(), 6'b000000); else passed++;
    total++; if (mem() !== 17'h00000) $display("FAIL idle_mem: got %h expected %h", mem(), 17'h00000); else passed++;
  endtask

  task automatic test_single_pass();
    start = 1'b1; key_in = 24'h000249; tick(); start = 1'b0;
    total++; if (ctl() !== 6'b100100) $display("FAIL sp_init_go: got %b expected %b", ctl(), 6'b100100); else passed++;
    total++; if (mem() !== {8'h11, 8'h22, 1'b1}) $display("FAIL sp_init_mem: got %h expected %h", mem(), {8'h11, 8'h22, 1'b1}); else passed++;
    total++; if (cur_key !== 24'h000249) $display("FAIL sp_key_init: got %h expected %h", cur_key, 24'h000249); else passed++;
    repeat (255) tick();
    total++; if (ctl() !== 6'b100000) $display("FAIL sp_init_wait: got %b expected %b", ctl(), 6'b100000); else passed++;
    pulse_init();
    total++; if (ctl() !== 6'b100010) $display("FAIL sp_shuf_go: got %b expected %b", ctl(), 6'b100010); else passed++;
    total++; if (mem() !== {8'h33, 8'h44, 1'b1}) $display("FAIL sp_shuf_mem: got %h expected %h", mem(), {8'h33, 8'h44, 1'b1}); else passed++;
    repeat (767) tick();
    total++; if (ctl() !== 6'b100000) $display("FAIL sp_shuf_wait: got %b expected %b", ctl(), 6'b100000); else passed++;
    pulse_shuf();
    total++; if (ctl() !== 6'b100001) $display("FAIL sp_dec_go: got %b expected %b", ctl(), 6'b100001); else passed++;
    repeat (31) tick();
    total++; if (mem() !== {8'h55, 8'h66, 1'b1}) $display("FAIL sp_dec_mem: got %h expected %h", mem(), {8'h55, 8'h66, 1'b1}); else passed++;
    total++; if (cur_key !== 24'h000249) $display("FAIL sp_key_dec: got %h expected %h", cur_key, 24'h000249); else passed++;
    pulse_dec(1'b0);
    total++; if (ctl() !== 6'b111000) $display("FAIL sp_pass: got %b expected %b", ctl(), 6'b111000); else passed++;
    total++; if (mem() !== 17'h00000) $display("FAIL sp_pass_mem: got %h expected %h", mem(), 17'h00000); else passed++;
    tick();
    total++; if (ctl() !== 6'b001000) $display("FAIL sp_idle: got %b expected %b", ctl(), 6'b001000); else passed++;
    total++; if (cur_key !== 24'h000249) $display("FAIL sp_key_hold: got %h expected %h", cur_key, 24'h000249); else passed++;
  endtask

  task automatic test_back_to_back();
    start = 1'b1; key_in = 24'h0000A0; tick(); start = 1'b0;
    tick(); pulse_init(); tick(); pulse_shuf(); tick();
    pulse_dec(1'b0);
    total++; if (ctl() !== 6'b111000) $display("FAIL b2b_pass: got %b expected %b", ctl(), 6'b111000); else passed++;
    start = 1'b1; key_in = 24'h0000B7; tick();
    total++; if (ctl() !== 6'b001000) $display("FAIL b2b_idle: got %b expected %b", ctl(), 6'b001000); else passed++;
    tick(); start = 1'b0;
    total++; if (ctl() !== 6'b100100) $display("FAIL b2b_restart: got %b expected %b", ctl(), 6'b100100); else passed++;
    total++; if (cur_key !== 24'h0000B7) $display("FAIL b2b_key: got %h expected %h", cur_key, 24'h0000B7); else passed++;
  endtask

`ifdef RC4_KEY_SEARCH_EN
  task automatic test_search();
    int init_go_seen;
    init_go_seen = 0;
    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; key_in = 24'h000010; tick(); start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (init_start === 1'b1) init_go_seen++;
      total++; if (cur_key !== 24'h000010 + k) $display("FAIL srch_key%0d: got %h expected %h", k, cur_key, 24'h000010 + k); else passed++;
      tick(); tick(); pulse_init(); tick(); pulse_shuf(); tick();
      pulse_dec(k < 3);
      if (k < 3) begin
        total++; if (ctl() !== 6'b100000) $display("FAIL srch_next%0d: got %b expected %b", k, ctl(), 6'b100000); else passed++;
        tick();
      end
    end
    total++; if (init_go_seen !== 4) $display("FAIL srch_init_go: got %0d expected %0d", init_go_seen, 4); else passed++;
    total++; if (ctl() !== 6'b111000) $display("FAIL srch_pass: got %b expected %b", ctl(), 6'b111000); else passed++;
    total++; if (cur_key !== 24'h000013) $display("FAIL srch_pass_key: got %h expected %h", cur_key, 24'h000013); else passed++;
    tick();
  endtask

  task automatic test_search_exhaust();
    start = 1'b1; key_in = 24'h000014; tick(); start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick(); tick(); pulse_init(); tick(); pulse_shuf(); tick();
      pulse_dec(1'b1);
      if (k == 0) tick();
    end
    tick();
    total++; if (ctl() !== 6'b110000) $display("FAIL exh_fail: got %b expected %b", ctl(), 6'b110000); else passed++;
    total++; if (cur_key !== 24'h000015) $display("FAIL exh_key: got %h expected %h", cur_key, 24'h000015); else passed++;
    tick();
    total++; if (ctl() !== 6'b000000) $display("FAIL exh_idle: got %b expected %b", ctl(), 6'b000000); else passed++;
  endtask
`else
  task automatic test_single_fail();
    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; key_in = 24'h0000AB; tick(); start = 1'b0;
    tick(); pulse_init(); tick(); pulse_shuf(); tick();
    dec_fail = 1'b1; tick(); tick(); dec_fail = 1'b0;
    total++; if (ctl() !== 6'b100000) $display("FAIL sf_fail_no_done: got %b expected %b", ctl(), 6'b100000); else passed++;
    pulse_dec(1'b1);
    total++; if (ctl() !== 6'b110000) $display("FAIL sf_fail: got %b expected %b", ctl(), 6'b110000); else passed++;
    total++; if (cur_key !== 24'h0000AB) $display("FAIL sf_key: got %h expected %h", cur_key, 24'h0000AB); else passed++;
    tick();
    total++; if (ctl() !== 6'b000000) $display("FAIL sf_idle: got %b expected %b", ctl(), 6'b000000); else passed++;
  endtask
`endif

  task automatic test_spurious();
    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; key_in = 24'h000321; tick(); start = 1'b0;
    tick();
    shuf_done = 1'b1; dec_done = 1'b1; tick(); shuf_done = 1'b0; dec_done = 1'b0;
    total++; if (ctl() !== 6'b100000) $display("FAIL spur_init_wait: got %b expected %b", ctl(), 6'b100000); else passed++;
    total++; if (mem() !== {8'h11, 8'h22, 1'b1}) $display("FAIL spur_init_mem: got %h expected %h", mem(), {8'h11, 8'h22, 1'b1}); else passed++;
    pulse_init(); tick();
    start = 1'b1; key_in = 24'h000777; init_done = 1'b1; tick(); start = 1'b0; init_done = 1'b0;
    total++; if (ctl() !== 6'b100000) $display("FAIL spur_shuf_wait: got %b expected %b", ctl(), 6'b100000); else passed++;
    total++; if (cur_key !== 24'h000321) $display("FAIL spur_key: got %h expected %h", cur_key, 24'h000321); else passed++;
    total++; if (mem() !== {8'h33, 8'h44, 1'b1}) $display("FAIL spur_shuf_mem: got %h expected %h", mem(), {8'h33, 8'h44, 1'b1}); else passed++;
  endtask

  task automatic test_async_reset();
    #2 reset = 1'b1;
    #1;
    total++; if (ctl() !== 6'b000000) $display("FAIL ar_ctl: got %b expected %b", ctl(), 6'b000000); else passed++;
    total++; if (mem() !== 17'h00000) $display("FAIL ar_mem: got %h expected %h", mem(), 17'h00000); else passed++;
    total++; if (cur_key !== 24'h000000) $display("FAIL ar_key: got %h expected %h", cur_key, 24'h000000); else passed++;
    #1 reset = 1'b0;
    start = 1'b1; key_in = 24'h000042; tick(); start = 1'b0;
    total++; if (ctl() !== 6'b100100) $display("FAIL ar_restart: got %b expected %b", ctl(), 6'b100100); else passed++;
    total++; if (cur_key !== 24'h000042) $display("FAIL ar_restart_key: got %h expected %h", cur_key, 24'h000042); else passed++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; key_in = 24'h000000;
    init_done = 1'b0; shuf_done = 1'b0; dec_done = 1'b0; dec_fail = 1'b0;
    init_addr = 8'h11; init_data = 8'h22; init_wren = 1'b1;
    shuf_addr = 8'h33; shuf_data = 8'h44; shuf_wren = 1'b1;
    dec_addr  = 8'h55; dec_data  = 8'h66; dec_wren  = 1'b1;
    test_reset();
    test_single_pass();
    test_back_to_back();
`ifdef RC4_KEY_SEARCH_EN
    test_search();
    test_search_exhaust();
`else
    test_single_fail();
`endif
    test_spurious();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
